// File: rtl/face_tx_pkg.sv
// face_tx_pkg: shared constants, record/packet types and packet assembly
// for the face-detection return path (detector -> laptop over UART).
package face_tx_pkg;

    localparam logic [7:0] SYNC_DET  = 8'hA5;
    localparam logic [7:0] SYNC_EOF  = 8'h5A;
    localparam int         PKT_BYTES = 7;

    // One buffered detection (or end-of-frame marker when is_eof is set)
    typedef struct packed {
        logic        is_eof;
        logic [3:0]  pyramid;
        logic [15:0] row;
        logic [15:0] col;
    } face_rec_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } tx_state_t;

    // Byte 0 is the first byte on the wire
    typedef logic [PKT_BYTES-1:0][7:0] pkt_t;

    // Coordinates wider than 16 bits clamp to the largest representable value
    function automatic logic [15:0] sat16(input logic [31:0] v);
        return (v[31:16] != 16'h0000) ? 16'hFFFF : v[15:0];
    endfunction

    // Frames a record into the 7-byte packet; the last byte is the XOR of bytes 1..5
    function automatic pkt_t build_packet(input face_rec_t rec);
        pkt_t p;
        if (rec.is_eof) begin
            p[0] = SYNC_EOF;
            p[1] = 8'hFF;
            p[2] = 8'h00;
            p[3] = 8'h00;
            p[4] = 8'h00;
            p[5] = 8'h00;
        end else begin
            p[0] = SYNC_DET;
            p[1] = {4'h0, rec.pyramid};
            p[2] = rec.row[15:8];
            p[3] = rec.row[7:0];
            p[4] = rec.col[15:8];
            p[5] = rec.col[7:0];
        end
        p[6] = p[1] ^ p[2] ^ p[3] ^ p[4] ^ p[5];
        return p;
    endfunction

endpackage

// File: rtl/face_coord_uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser for one byte. A start pulse is accepted when
// idle or on the final cycle of the current stop bit, so consecutive bytes
// leave no idle gap. done is high during that final stop-bit cycle.
// CLKS_PER_BIT must be at least 2.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       line,
    output logic       done
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic          active;
    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    frame;

    assign done = active && (bit_cnt == 4'd9) && (clk_cnt == CW'(CLKS_PER_BIT - 1));

    // Bit-time counter and shift register driving the registered line output
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            active  <= 1'b0;
            clk_cnt <= '0;
            bit_cnt <= '0;
            frame   <= '1;
            line    <= 1'b1;
        end else if (start && (!active || done)) begin
            active  <= 1'b1;
            clk_cnt <= '0;
            bit_cnt <= '0;
            frame   <= {1'b1, data};
            line    <= 1'b0;
        end else if (active) begin
            if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                clk_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    active <= 1'b0;
                    line   <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    line    <= frame[0];
                    frame   <= {1'b1, frame[8:1]};
                end
            end else begin
                clk_cnt <= clk_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/face_coord_uart_tx.sv
// face_coord_uart_tx: buffers face detections from the VJ pipeline in a small
// FIFO and sends each one as a 7-byte packet on a UART 8N1 line. The pipeline
// never stalls, so a full FIFO drops the record and raises a sticky overflow.
// Optional build macro FACE_TX_FRAME_DONE_EN adds a frame_done input that
// enqueues an end-of-frame marker packet.
module face_coord_uart_tx
    import face_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0][31:0] face_coords,
    input  logic             face_coords_ready,
    input  logic [3:0]       pyramid_number,
    input  logic             clear_overflow,
`ifdef FACE_TX_FRAME_DONE_EN
    input  logic             frame_done,
`endif
    output logic             uart_tx,
    output logic             tx_busy,
    output logic             overflow,
    output logic [7:0]       drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    face_rec_t     mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic          wr_req;
    face_rec_t     det_rec;
    face_rec_t     wr_rec;

    tx_state_t     state;
    face_rec_t     cur_rec;
    logic [2:0]    byte_idx;
    pkt_t          pkt;
    logic          byte_start;
    logic          byte_done;
    logic [7:0]    byte_data;

    assign det_rec = '{is_eof:  1'b0,
                       pyramid: pyramid_number,
                       row:     sat16(face_coords[0]),
                       col:     sat16(face_coords[1])};

`ifdef FACE_TX_FRAME_DONE_EN
    logic eof_pending;

    // A marker that collides with a detection waits one cycle behind it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            eof_pending <= 1'b0;
        end else begin
            eof_pending <= face_coords_ready && (eof_pending || frame_done);
        end
    end

    assign wr_req = face_coords_ready || eof_pending || frame_done;
    assign wr_rec = face_coords_ready ? det_rec
                                      : '{is_eof: 1'b1, pyramid: 4'h0, row: 16'h0000, col: 16'h0000};
`else
    assign wr_req = face_coords_ready;
    assign wr_rec = det_rec;
`endif

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign pop     = (state == IDLE) && !empty;
    assign push    = wr_req && (!full || pop);
    assign drop    = wr_req && full && !pop;
    assign tx_busy = (state != IDLE) || !empty;

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_rec;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky drop flag and saturating drop counter; a drop beats a coincident clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= 8'h00;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_overflow) begin
                drop_count <= 8'h01;
            end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= 8'h00;
        end
    end

    // Packet sequencer: pop a record, then feed its seven bytes to the serialiser
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cur_rec  <= '0;
            byte_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        cur_rec <= mem[rd_ptr];
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    byte_idx <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    if (byte_done) begin
                        if (byte_idx == 3'(PKT_BYTES - 1)) begin
                            state <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pkt = build_packet(cur_rec);

    // Start the first byte from LOAD and each following byte on the previous stop bit's last cycle
    always_comb begin
        byte_start = 1'b0;
        byte_data  = 8'h00;
        if (state == LOAD) begin
            byte_start = 1'b1;
            byte_data  = pkt[0];
        end else if ((state == SEND) && byte_done && (byte_idx != 3'(PKT_BYTES - 1))) begin
            byte_start = 1'b1;
            byte_data  = pkt[byte_idx + 3'd1];
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (byte_start),
        .data    (byte_data),
        .line    (uart_tx),
        .done    (byte_done)
    );

endmodule
